// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream master.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_t;

  localparam int unsigned C_DROP_CNT_W = 16;

  // Saturating add for the discarded-word counter.
  function automatic logic [C_DROP_CNT_W-1:0] sat_add_drop(
    input logic [C_DROP_CNT_W-1:0] a,
    input logic [C_DROP_CNT_W-1:0] b
  );
    logic [C_DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[C_DROP_CNT_W] ? '1 : sum[C_DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular buffer holding words returned by the FIFO until the stream
// consumer accepts them.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : drop all entries (priority over push/pop)
//   i_push, i_data : write one word at the tail (ignored when full without pop)
//   i_pop          : retire the head word (ignored when empty)
//   o_data         : head word
//   o_count        : number of valid entries
module stream_skid_buf #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_BUF_DEPTH  = 3,
  parameter int unsigned P_COUNT_W    = $clog2(P_BUF_DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic [P_DATA_WIDTH-1:0] i_data,
  input  logic                    i_pop,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic [P_COUNT_W-1:0]    o_count
);

  localparam int unsigned C_PTR_W = (P_BUF_DEPTH > 1) ? $clog2(P_BUF_DEPTH) : 1;

  logic [P_DATA_WIDTH-1:0] mem_q [P_BUF_DEPTH];
  logic [C_PTR_W-1:0]      wr_ptr_q;
  logic [C_PTR_W-1:0]      rd_ptr_q;
  logic [P_COUNT_W-1:0]    count_q;
  logic                    pop_ok;
  logic                    push_ok;

  // Pointer increment with wrap at a possibly non-power-of-two depth.
  function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
    return (p == C_PTR_W'(P_BUF_DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
  endfunction

  assign pop_ok  = i_pop && (count_q != '0);
  assign push_ok = i_push && ((count_q != P_COUNT_W'(P_BUF_DEPTH)) || pop_ok);

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(P_BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + P_COUNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - P_COUNT_W'(1);
      end
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO: issues reads, absorbs the one-cycle
// read latency and presents the words as a valid/ready stream at up to one
// word per clock. Supports enable, a flush/drain mode and word counters.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_enable, i_flush       : fetch enable, one-cycle drain/discard request
//   o_fifo_rden             : FIFO read enable
//   i_fifo_rdata            : FIFO read data
//   i_fifo_rddata_valid     : FIFO read data valid (one cycle after rden)
//   i_fifo_level            : FIFO occupancy
//   o_m_valid/o_m_data      : stream out, i_m_ready : stream back-pressure
//   o_state, o_busy         : FSM state and activity indication
//   o_words_out             : words accepted downstream (wrapping)
//   o_words_dropped         : words discarded by flush (saturating)
//   o_err_overflow          : sticky, a return arrived with the buffer full
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH  = 8,
  parameter int unsigned P_FIFO_DEPTH  = 16,
  parameter int unsigned P_FIFO_DWIDTH = $clog2(P_FIFO_DEPTH),
  parameter int unsigned P_BUF_DEPTH   = 3,
  parameter int unsigned P_CNT_WIDTH   = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic                     i_flush,
  output logic                     o_fifo_rden,
  input  logic [P_DATA_WIDTH-1:0]  i_fifo_rdata,
  input  logic                     i_fifo_rddata_valid,
  input  logic [P_FIFO_DWIDTH:0]   i_fifo_level,
  output logic                     o_m_valid,
  output logic [P_DATA_WIDTH-1:0]  o_m_data,
  input  logic                     i_m_ready,
  output logic [1:0]               o_state,
  output logic                     o_busy,
  output logic [P_CNT_WIDTH-1:0]   o_words_out,
  output logic [C_DROP_CNT_W-1:0]  o_words_dropped,
  output logic                     o_err_overflow
);

  localparam int unsigned C_BUF_CNT_W = $clog2(P_BUF_DEPTH + 1);
  localparam int unsigned C_ISSUE_W   = C_BUF_CNT_W + 1;

  rd_state_t                state_q;
  rd_state_t                state_d;
  logic                     inflight_q;
  logic                     rden_c;
  logic                     m_valid_c;
  logic                     flush_go;
  logic                     push;
  logic                     pop;
  logic                     overflow;
  logic [C_BUF_CNT_W-1:0]   buf_count;
  logic [P_DATA_WIDTH-1:0]  buf_data;
  logic [C_DROP_CNT_W-1:0]  drop_inc;
  logic [P_CNT_WIDTH-1:0]   words_out_q;
  logic [C_DROP_CNT_W-1:0]  dropped_q;
  logic                     err_q;

  // A flush request while already draining is ignored.
  assign flush_go = i_flush && (state_q != ST_FLUSH);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush wins over enable.
  always_comb begin
    state_d = state_q;
    if (flush_go) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_enable) state_d = ST_RUN;
        ST_RUN:   if (!i_enable) state_d = ST_IDLE;
        ST_FLUSH: if ((i_fifo_level == '0) && !inflight_q) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs. Issue only while buffer plus outstanding read leaves a free
  // slot, so the returning word always has somewhere to land; i_m_ready is
  // deliberately kept out of this path.
  always_comb begin
    rden_c    = 1'b0;
    m_valid_c = (buf_count != '0) && (state_q != ST_FLUSH);
    case (state_q)
      ST_RUN: rden_c = (i_fifo_level != '0) &&
                       (({1'b0, buf_count} + C_ISSUE_W'(inflight_q)) < C_ISSUE_W'(P_BUF_DEPTH));
      ST_FLUSH: rden_c = (i_fifo_level != '0);
      default: rden_c = 1'b0;
    endcase
  end

  // Buffer control. Returns arriving on the flush-entry cycle are discarded.
  assign pop      = m_valid_c && i_m_ready;
  assign push     = i_fifo_rddata_valid && (state_q != ST_FLUSH) && !flush_go;
  assign overflow = push && (buf_count == C_BUF_CNT_W'(P_BUF_DEPTH)) && !pop;

  // Words discarded this cycle: on flush entry, everything buffered that is not
  // being accepted right now, plus any word returning in the same cycle.
  always_comb begin
    drop_inc = '0;
    if (flush_go) begin
      drop_inc = C_DROP_CNT_W'(buf_count) - C_DROP_CNT_W'(pop) +
                 C_DROP_CNT_W'(i_fifo_rddata_valid);
    end else if ((state_q == ST_FLUSH) && i_fifo_rddata_valid) begin
      drop_inc = C_DROP_CNT_W'(1);
    end
  end

  stream_skid_buf #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_BUF_DEPTH  (P_BUF_DEPTH),
    .P_COUNT_W    (C_BUF_CNT_W)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (flush_go),
    .i_push  (push),
    .i_data  (i_fifo_rdata),
    .i_pop   (pop),
    .o_data  (buf_data),
    .o_count (buf_count)
  );

  // Outstanding-read flag, counters and sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_q  <= 1'b0;
      words_out_q <= '0;
      dropped_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      inflight_q <= rden_c;
      if (pop) begin
        words_out_q <= words_out_q + P_CNT_WIDTH'(1);
      end
      dropped_q <= sat_add_drop(dropped_q, drop_inc);
      if (overflow) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_fifo_rden     = rden_c;
  assign o_m_valid       = m_valid_c;
  assign o_m_data        = buf_data;
  assign o_state         = state_q;
  assign o_busy          = (state_q != ST_IDLE) || (buf_count != '0) || inflight_q;
  assign o_words_out     = words_out_q;
  assign o_words_dropped = dropped_q;
  assign o_err_overflow  = err_q;

`ifdef SVA
  a_rden_level : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_fifo_rden |-> (i_fifo_level != '0));
  a_rden_rvalid : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_fifo_rden |=> i_fifo_rddata_valid);
  a_hold : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_m_valid && !i_m_ready && !i_flush) |=> (o_m_valid && $stable(o_m_data)));
  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !overflow);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 5;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          flush;
  logic          rden;
  logic [DW-1:0] rdata;
  logic          rdvalid;
  logic [LW-1:0] level;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    state;
  logic          busy;
  logic [31:0]   words_out;
  logic [15:0]   dropped;
  logic          err;

  int total;
  int bad;
  int cyc;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] rx[$];
  int            rx_cyc[$];
  logic          hold_pend;
  logic [DW-1:0] hold_data;

  typedef struct {
    int         n;
    logic [7:0] base;
    logic [3:0] rdy_pat;
    int         exp_words;
    bit         chk_span;
    int         exp_span;
  } vec_t;

  vec_t vecs[4];

  fifo_stream_reader dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_enable            (enable),
    .i_flush             (flush),
    .o_fifo_rden         (rden),
    .i_fifo_rdata        (rdata),
    .i_fifo_rddata_valid (rdvalid),
    .i_fifo_level        (level),
    .o_m_valid           (m_valid),
    .o_m_data            (m_data),
    .i_m_ready           (m_ready),
    .o_state             (state),
    .o_busy              (busy),
    .o_words_out         (words_out),
    .o_words_dropped     (dropped),
    .o_err_overflow      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'(base + i));
  endtask

  // Sync FIFO model: one-cycle read latency, level refreshed on both edges.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (!rst_n) begin
        rdvalid <= 1'b0;
        rdata   <= '0;
      end else begin
        rdvalid <= rden;
        if (rden && fq.size() > 0) rdata <= fq.pop_front();
      end
    end
    level <= LW'(fq.size());
  end

  // Stream collector and hold-stability monitor.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(hold_data));
      end
      if (m_valid && m_ready) begin
        rx.push_back(m_data);
        rx_cyc.push_back(cyc);
      end
      hold_pend = m_valid && !m_ready && !flush;
      hold_data = m_data;
    end
  end

  initial begin
    logic [31:0] w0;
    logic [15:0] d0;
    int          mism;

    total = 0; bad = 0; cyc = 0;
    hold_pend = 1'b0; hold_data = '0;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;

    vecs[0] = '{n: 16, base: 8'h10, rdy_pat: 4'b1111, exp_words: 16, chk_span: 1'b1, exp_span: 15};
    vecs[1] = '{n: 8,  base: 8'h40, rdy_pat: 4'b1001, exp_words: 8,  chk_span: 1'b0, exp_span: 0};
    vecs[2] = '{n: 5,  base: 8'h60, rdy_pat: 4'b0101, exp_words: 5,  chk_span: 1'b0, exp_span: 0};
    vecs[3] = '{n: 3,  base: 8'hC0, rdy_pat: 4'b0001, exp_words: 3,  chk_span: 1'b0, exp_span: 0};

    // Reset state
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_rden", 32'(rden), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words_out", words_out, 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // First-word latency and back-to-back delivery
    rx.delete();
    preload(8'hA0, 5);
    tick();
    m_ready = 1'b1;
    enable  = 1'b1;
    tick();
    check("t1_rden", 32'(rden), 32'd1);
    check("t1_valid_e0", 32'(m_valid), 32'd0);
    tick();
    check("t1_valid_e1", 32'(m_valid), 32'd0);
    tick();
    check("t1_valid_e2", 32'(m_valid), 32'd1);
    check("t1_data0", 32'(m_data), 32'hA0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("t1_valid_n", 32'(m_valid), 32'd1);
      check("t1_data_n", 32'(m_data), 32'(8'hA0 + i));
    end
    tick();
    check("t1_valid_end", 32'(m_valid), 32'd0);
    check("t1_words_out", words_out, 32'd5);
    enable = 1'b0;
    tick(); tick();
    check("t1_state_idle", 32'(state), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // Table-driven streaming with ready patterns
    for (int v = 0; v < 4; v++) begin
      rx.delete();
      rx_cyc.delete();
      w0 = words_out;
      preload(vecs[v].base, vecs[v].n);
      tick();
      enable = 1'b1;
      for (int k = 0; k < 300 && rx.size() < vecs[v].n; k++) begin
        m_ready = vecs[v].rdy_pat[k % 4];
        tick();
      end
      enable  = 1'b0;
      m_ready = 1'b1;
      tick(); tick(); tick();
      check("vec_count", 32'(rx.size()), 32'(vecs[v].exp_words));
      mism = 0;
      for (int i = 0; i < rx.size(); i++) begin
        if (rx[i] !== 8'(vecs[v].base + i)) mism++;
      end
      check("vec_order", 32'(mism), 32'd0);
      check("vec_words_out", words_out - w0, 32'(vecs[v].exp_words));
      check("vec_level", 32'(level), 32'd0);
      check("vec_err", 32'(err), 32'd0);
      check("vec_state", 32'(state), 32'd0);
      check("vec_busy", 32'(busy), 32'd0);
      if (vecs[v].chk_span && rx_cyc.size() == vecs[v].n) begin
        check("vec_span", 32'(rx_cyc[vecs[v].n - 1] - rx_cyc[0]), 32'(vecs[v].exp_span));
      end
    end

    // Flush after three words accepted
    rx.delete();
    w0 = words_out;
    d0 = dropped;
    preload(8'h80, 10);
    tick();
    m_ready = 1'b1;
    enable  = 1'b1;
    for (int k = 0; k < 50 && (words_out - w0) < 3; k++) tick();
    m_ready = 1'b0;
    enable  = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_valid_off", 32'(m_valid), 32'd0);
    check("t4_state_flush", 32'(state), 32'd2);
    for (int k = 0; k < 50 && state != 2'd0; k++) tick();
    check("t4_state_idle", 32'(state), 32'd0);
    check("t4_level", 32'(level), 32'd0);
    check("t4_dropped", 32'(dropped - d0), 32'd7);
    check("t4_words_out", words_out - w0, 32'd3);
    check("t4_busy", 32'(busy), 32'd0);
    mism = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== 8'(8'h80 + i)) mism++;
    check("t4_order", 32'(mism), 32'd0);

    // Enable dropped with a read in flight
    rx.delete();
    preload(8'h20, 6);
    tick();
    m_ready = 1'b1;
    enable  = 1'b1;
    tick();
    tick();
    check("t5_rden_run", 32'(rden), 32'd1);
    enable = 1'b0;
    tick();
    check("t5_rden_off", 32'(rden), 32'd0);
    check("t5_state", 32'(state), 32'd0);
    check("t5_valid_a", 32'(m_valid), 32'd1);
    check("t5_data_a", 32'(m_data), 32'h20);
    tick();
    check("t5_valid_b", 32'(m_valid), 32'd1);
    check("t5_data_b", 32'(m_data), 32'h21);
    check("t5_rden_still_off", 32'(rden), 32'd0);
    tick();
    check("t5_valid_gone", 32'(m_valid), 32'd0);
    check("t5_level", 32'(level), 32'd4);
    enable = 1'b1;
    for (int k = 0; k < 50 && rx.size() < 6; k++) tick();
    enable = 1'b0;
    tick(); tick();
    check("t5_count", 32'(rx.size()), 32'd6);
    mism = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== 8'(8'h20 + i)) mism++;
    check("t5_order", 32'(mism), 32'd0);

    // Async reset with the buffer full
    rx.delete();
    preload(8'hE0, 6);
    tick();
    m_ready = 1'b0;
    enable  = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("t6_valid_full", 32'(m_valid), 32'd1);
    check("t6_data_full", 32'(m_data), 32'hE0);
    check("t6_rden_full", 32'(rden), 32'd0);
    check("t6_busy_full", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_state", 32'(state), 32'd0);
    check("t6_valid", 32'(m_valid), 32'd0);
    check("t6_data", 32'(m_data), 32'd0);
    check("t6_rden", 32'(rden), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_words_out", words_out, 32'd0);
    check("t6_dropped", 32'(dropped), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    enable = 1'b0;
    tick(); tick();
    fq.delete();
    rst_n = 1'b1;
    tick(); tick();
    check("t6_state_after", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
